// File: rtl/eu_ybuf_mp.sv
// ---------------------------------------------------------------------------
// eu_ybuf_mp
//
// Multi-port, consumer-counted result buffer for an execution-unit cache.
// ALU results are written direct-mapped by local address and carry a count of
// the operand reads that will consume them. Operand ports read the buffer
// combinationally with a tag check. Each granted read uses up one reference,
// and an entry is released on the edge where its last reference is consumed.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         synchronous reset, active-high, highest priority
//   flush_i       invalidate every entry at the next edge
//   rd_addr_i     per-port operand address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_valid_i    per-port request valid
//   rd_data_o     per-port operand data, zero unless the port matches an entry
//   rd_success_o  per-port read granted this cycle
//   wr_addr_i     result address
//   wr_data_i     result data
//   wr_cnt_i      number of consumers for the result (0 is rejected)
//   wr_valid_i    result valid
//   wr_success_o  result accepted this cycle
//   occupancy_o   registered count of valid entries
// ---------------------------------------------------------------------------
module eu_ybuf_mp #(
    parameter int NUM_IDX_BITS = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_RD_PORTS = 2,
    parameter int CNT_BITS     = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_i,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [NUM_RD_PORTS-1:0]            rd_valid_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD_PORTS-1:0]            rd_success_o,
    input  logic [ADDR_WIDTH-1:0]              wr_addr_i,
    input  logic [DATA_WIDTH-1:0]              wr_data_i,
    input  logic [CNT_BITS-1:0]                wr_cnt_i,
    input  logic                               wr_valid_i,
    output logic                               wr_success_o,
    output logic [NUM_IDX_BITS:0]              occupancy_o
);

    localparam int NUM_ENTRIES = 1 << NUM_IDX_BITS;
    localparam int TAG_WIDTH   = ADDR_WIDTH - NUM_IDX_BITS;
    localparam int OCC_WIDTH   = NUM_IDX_BITS + 1;

    // Control state (reset) and payload state (not reset).
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [CNT_BITS-1:0]    cnt_q  [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   tag_q  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  data_q [NUM_ENTRIES];
    logic [OCC_WIDTH-1:0]   occ_q;

    // Read-side decode and arbitration.
    logic [NUM_IDX_BITS-1:0] rd_idx [NUM_RD_PORTS];
    logic [TAG_WIDTH-1:0]    rd_tag [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] rd_match;
    logic [NUM_RD_PORTS-1:0] rd_grant;
    logic [31:0]             rank;

    // Per-entry consumption this cycle.
    logic [CNT_BITS-1:0]     dec_cnt [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  freed;
    logic [OCC_WIDTH-1:0]    freed_num;

    // Write-side decode.
    logic [NUM_IDX_BITS-1:0] wr_idx;
    logic [TAG_WIDTH-1:0]    wr_tag;

    // A port is served when fewer earlier ports already claimed the same
    // entry than the entry has references left.
    function automatic logic within_quota(input logic [31:0] prior,
                                          input logic [CNT_BITS-1:0] cnt);
        return prior < 32'(cnt);
    endfunction

    assign wr_idx = wr_addr_i[NUM_IDX_BITS-1:0];
    assign wr_tag = wr_addr_i[ADDR_WIDTH-1:NUM_IDX_BITS];

    always_comb begin
        rd_match     = '0;
        rd_grant     = '0;
        rd_data_o    = '0;
        rd_success_o = '0;
        rank         = '0;

        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_idx[p]   = rd_addr_i[p*ADDR_WIDTH +: NUM_IDX_BITS];
            rd_tag[p]   = rd_addr_i[p*ADDR_WIDTH + NUM_IDX_BITS +: TAG_WIDTH];
            rd_match[p] = rd_valid_i[p] && valid_q[rd_idx[p]]
                          && (tag_q[rd_idx[p]] == rd_tag[p]);
            if (rd_match[p]) begin
                rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data_q[rd_idx[p]];
            end
        end

        // Ascending port order: the rank of a port is the number of lower
        // ports hitting the same entry.
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rank = '0;
            for (int q = 0; q < p; q++) begin
                if (rd_match[q] && (rd_idx[q] == rd_idx[p])) begin
                    rank = rank + 32'd1;
                end
            end
            rd_grant[p] = rd_match[p] && within_quota(rank, cnt_q[rd_idx[p]])
                          && !flush_i && !reset;
        end
        rd_success_o = rd_grant;
    end

    // Grants never exceed cnt, so the decrement fits in CNT_BITS and an
    // entry frees exactly when its decrement equals its remaining count.
    always_comb begin
        freed     = '0;
        freed_num = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            dec_cnt[e] = '0;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (rd_grant[p] && (rd_idx[p] == NUM_IDX_BITS'(e))) begin
                    dec_cnt[e] = dec_cnt[e] + CNT_BITS'(1);
                end
            end
            freed[e]  = valid_q[e] && (dec_cnt[e] != '0) && (dec_cnt[e] == cnt_q[e]);
            freed_num = freed_num + OCC_WIDTH'(freed[e]);
        end
    end

    // Availability is judged on pre-edge state: a slot released this cycle
    // still looks occupied to the writer.
    assign wr_success_o = wr_valid_i && !valid_q[wr_idx] && (wr_cnt_i != '0)
                          && !flush_i && !reset;

    assign occupancy_o = occ_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                // A write and a read never target the same entry together:
                // writes need an empty slot, reads need a valid one.
                if (wr_success_o && (wr_idx == NUM_IDX_BITS'(e))) begin
                    valid_q[e] <= 1'b1;
                    cnt_q[e]   <= wr_cnt_i;
                end else if (dec_cnt[e] != '0) begin
                    cnt_q[e] <= cnt_q[e] - dec_cnt[e];
                    if (freed[e]) begin
                        valid_q[e] <= 1'b0;
                    end
                end
            end
            occ_q <= occ_q + OCC_WIDTH'(wr_success_o) - freed_num;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_success_o) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_eu_ybuf_mp.sv
// ---------------------------------------------------------------------------
// tb_eu_ybuf_mp
//
// Directed bench for eu_ybuf_mp with default parameters (4 entries, 8-bit
// addresses, 16-bit data, 2 read ports, 2-bit consumer count). Address map:
// 0x05 -> idx 1 tag 1, 0x09 -> idx 1 tag 2, 0x06 -> idx 2 tag 1.
// ---------------------------------------------------------------------------
module tb_eu_ybuf_mp;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic [15:0] rd_addr_i;
    logic [1:0]  rd_valid_i;
    logic [31:0] rd_data_o;
    logic [1:0]  rd_success_o;
    logic [7:0]  wr_addr_i;
    logic [15:0] wr_data_i;
    logic [1:0]  wr_cnt_i;
    logic        wr_valid_i;
    logic        wr_success_o;
    logic [2:0]  occupancy_o;

    int total;
    int bad;

    eu_ybuf_mp dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .rd_addr_i    (rd_addr_i),
        .rd_valid_i   (rd_valid_i),
        .rd_data_o    (rd_data_o),
        .rd_success_o (rd_success_o),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_cnt_i     (wr_cnt_i),
        .wr_valid_i   (wr_valid_i),
        .wr_success_o (wr_success_o),
        .occupancy_o  (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after changing inputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle();
        flush_i    = 1'b0;
        rd_addr_i  = '0;
        rd_valid_i = '0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        wr_cnt_i   = '0;
        wr_valid_i = 1'b0;
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] c);
        wr_addr_i  = a;
        wr_data_i  = d;
        wr_cnt_i   = c;
        wr_valid_i = 1'b1;
    endtask

    task automatic set_rd(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1);
        rd_valid_i = v;
        rd_addr_i  = {a1, a0};
    endtask

    task automatic fill_all();
        logic [7:0] addrs [4];
        addrs[0] = 8'h00;
        addrs[1] = 8'h05;
        addrs[2] = 8'h06;
        addrs[3] = 8'h07;
        for (int i = 0; i < 4; i++) begin
            set_wr(addrs[i], 16'h1000 + 16'(i), 2'd1);
            settle();
            check("fill_wr_success", 32'(wr_success_o), 32'd1);
            tick();
        end
        idle();
        settle();
        check("fill_occupancy", 32'(occupancy_o), 32'd4);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("reset_occupancy", 32'(occupancy_o), 32'd0);
        check("reset_wr_success", 32'(wr_success_o), 32'd0);
        check("reset_rd_success", 32'(rd_success_o), 32'd0);
        check("reset_rd_data", rd_data_o, 32'd0);

        // Basic write/read with a single consumer.
        set_wr(8'h05, 16'hBEEF, 2'd1);
        settle();
        check("basic_wr_success", 32'(wr_success_o), 32'd1);
        tick();
        idle();
        set_rd(2'b01, 8'h05, 8'h00);
        settle();
        check("basic_rd_success", 32'(rd_success_o), 32'b01);
        check("basic_rd_data", rd_data_o, 32'h0000_BEEF);
        check("basic_occ_before", 32'(occupancy_o), 32'd1);
        tick();
        settle();
        check("basic_occ_after", 32'(occupancy_o), 32'd0);
        check("basic_reread_success", 32'(rd_success_o), 32'b00);
        check("basic_reread_data", rd_data_o, 32'd0);

        // Multi-consumer: two reads in one cycle, then the last read.
        idle();
        set_wr(8'h06, 16'h1234, 2'd3);
        settle();
        check("multi_wr_success", 32'(wr_success_o), 32'd1);
        tick();
        idle();
        set_rd(2'b11, 8'h06, 8'h06);
        settle();
        check("multi_both_success", 32'(rd_success_o), 32'b11);
        check("multi_both_data", rd_data_o, 32'h1234_1234);
        tick();
        set_rd(2'b10, 8'h00, 8'h06);
        settle();
        check("multi_last_success", 32'(rd_success_o), 32'b10);
        check("multi_occ_before_free", 32'(occupancy_o), 32'd1);
        tick();
        idle();
        settle();
        check("multi_occ_after_free", 32'(occupancy_o), 32'd0);

        // Over-subscription: one reference, two readers.
        set_wr(8'h06, 16'h5678, 2'd1);
        settle();
        check("over_wr_success", 32'(wr_success_o), 32'd1);
        tick();
        idle();
        set_rd(2'b11, 8'h06, 8'h06);
        settle();
        check("over_success", 32'(rd_success_o), 32'b01);
        tick();
        settle();
        check("over_after_success", 32'(rd_success_o), 32'b00);
        check("over_after_occ", 32'(occupancy_o), 32'd0);

        // Tag mismatch and busy slot: 0x05 resident with two references.
        idle();
        set_wr(8'h05, 16'hBEEF, 2'd2);
        settle();
        check("tag_wr_success", 32'(wr_success_o), 32'd1);
        tick();
        idle();
        set_rd(2'b01, 8'h09, 8'h00);
        set_wr(8'h09, 16'hAAAA, 2'd1);
        settle();
        check("tag_miss_success", 32'(rd_success_o), 32'b00);
        check("tag_miss_data", rd_data_o, 32'd0);
        check("busy_wr_success", 32'(wr_success_o), 32'd0);
        check("tag_occ", 32'(occupancy_o), 32'd1);
        tick();
        idle();
        set_rd(2'b01, 8'h05, 8'h00);
        settle();
        check("busy_keep_success", 32'(rd_success_o), 32'b01);
        check("busy_keep_data", rd_data_o, 32'h0000_BEEF);
        tick();

        // Last read of 0x05 alongside a write to the same index.
        set_rd(2'b01, 8'h05, 8'h00);
        set_wr(8'h09, 16'hAAAA, 2'd1);
        settle();
        check("freerw_rd_success", 32'(rd_success_o), 32'b01);
        check("freerw_wr_success", 32'(wr_success_o), 32'd0);
        tick();
        rd_valid_i = 2'b00;
        settle();
        check("retry_occ", 32'(occupancy_o), 32'd0);
        check("retry_wr_success", 32'(wr_success_o), 32'd1);
        tick();
        idle();
        set_rd(2'b10, 8'h00, 8'h09);
        set_wr(8'h06, 16'h4444, 2'd0);
        settle();
        check("retry_rd_success", 32'(rd_success_o), 32'b10);
        check("retry_rd_data", rd_data_o, 32'hAAAA_0000);
        check("cnt0_wr_success", 32'(wr_success_o), 32'd0);
        tick();
        idle();
        settle();
        check("cnt0_occ", 32'(occupancy_o), 32'd0);

        // Flush with a full buffer.
        fill_all();
        flush_i = 1'b1;
        set_rd(2'b11, 8'h00, 8'h05);
        set_wr(8'h04, 16'h7777, 2'd1);
        settle();
        check("flush_rd_success", 32'(rd_success_o), 32'b00);
        check("flush_wr_success", 32'(wr_success_o), 32'd0);
        tick();
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        settle();
        check("flush_occ_after", 32'(occupancy_o), 32'd0);
        check("flush_rd_after", 32'(rd_success_o), 32'b00);
        check("flush_data_after", rd_data_o, 32'd0);

        // Same sequence with reset in place of flush.
        idle();
        fill_all();
        reset = 1'b1;
        set_rd(2'b11, 8'h06, 8'h07);
        set_wr(8'h04, 16'h7777, 2'd1);
        settle();
        check("rst_rd_success", 32'(rd_success_o), 32'b00);
        check("rst_wr_success", 32'(wr_success_o), 32'd0);
        tick();
        reset      = 1'b0;
        wr_valid_i = 1'b0;
        settle();
        check("rst_occ_after", 32'(occupancy_o), 32'd0);
        check("rst_rd_after", 32'(rd_success_o), 32'b00);
        check("rst_data_after", rd_data_o, 32'd0);

        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eu_ybuf_mp.md
# eu_ybuf_mp

Multi-port, consumer-counted result buffer for an execution-unit cache, sitting between the ALU result path and the operand-fetch ports of the same execution unit. It generalises the single-result/two-operand y-buffer in three ways: parametrised depth, width and read-port count; a per-entry consumer count, so an entry is freed only after its last scheduled reader; and a global flush. Results are written direct-mapped by local address. Operands are read combinationally with tag check, and each successful read consumes one reference.

## Interface
Parameters:
- NUM_IDX_BITS, 2, number of entries is 2**NUM_IDX_BITS; the index is addr[NUM_IDX_BITS-1:0]
- ADDR_WIDTH, 8, local address width; the tag is addr[ADDR_WIDTH-1:NUM_IDX_BITS]
- DATA_WIDTH, 16, result data width
- NUM_RD_PORTS, 2, number of operand read ports (at least 1)
- CNT_BITS, 2, consumer-count width; the maximum number of consumers is 2**CNT_BITS-1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous reset, active-high
- flush_i  in  1  invalidate all entries
- rd_addr_i  in  NUM_RD_PORTS*ADDR_WIDTH  operand request addresses; port p is bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- rd_valid_i  in  NUM_RD_PORTS  per-port request valid
- rd_data_o  out  NUM_RD_PORTS*DATA_WIDTH  per-port operand data
- rd_success_o  out  NUM_RD_PORTS  per-port read granted this cycle
- wr_addr_i  in  ADDR_WIDTH  result address
- wr_data_i  in  DATA_WIDTH  result data
- wr_cnt_i  in  CNT_BITS  number of consumers for this result
- wr_valid_i  in  1  result valid
- wr_success_o  out  1  result accepted this cycle
- occupancy_o  out  NUM_IDX_BITS+1  number of valid entries

## Operation
- Per-entry state: valid, tag, data, cnt. After reset, all valid bits and all cnt values are 0.
- Match for port p: rd_valid_i[p], valid[idx] and tag equality, all true.
- Grant arbitration per entry: matching ports are granted in ascending port order, up to the current cnt. Ports in excess of cnt get rd_success_o=0.
- rd_success_o[p] = match and grant and ~flush_i.
- rd_data_o[p] = entry data when the match is true; 0 otherwise. The data is only meaningful when rd_success_o[p] is high.
- At the clock edge, each entry's cnt decreases by its number of granted ports. When cnt reaches 0, valid clears in the same edge.
- Write acceptance: wr_success_o = wr_valid_i & ~valid[wr idx] & (wr_cnt_i != 0) & ~flush_i.
  - Availability uses the pre-edge state. An entry being freed in this cycle cannot be rewritten in the same cycle.
- On an accepted write, at the edge: valid=1, tag, data and cnt=wr_cnt_i are loaded.
- A rejected write leaves state unchanged. The producer holds and retries; the block has no internal staging.
- A write never conflicts with a read of the same entry in the same cycle: a write needs valid=0, and a read needs valid=1.
- flush_i: at the edge, all valid and cnt are cleared. Flush overrides writes and reads in that cycle.
- occupancy_o is a register that tracks the number of set valid bits. Next value = current + accepted write − entries freed by reads, or 0 on flush.

## Timing
- Reads are combinational, with 0-cycle latency from rd_addr_i/rd_valid_i to rd_data_o/rd_success_o.
- A written result is readable from the cycle after wr_success_o. Write-to-read latency is 1; there is no same-cycle bypass.
- A freed entry is writable from the cycle after the last granted read.
- Reset: with inputs idle, all outputs are 0.
  - occupancy_o=0 on the first cycle after reset.
  - reset has priority over flush, write and read.
  - Reset asserted mid-operation discards all entries at that edge.
- No input path is registered. wr_success_o and rd_success_o are combinational from inputs and state.

## Test plan
- Basic write/read:
  - Reset, then write addr 0x05 data 0xBEEF cnt 1 → wr_success_o=1.
  - Next cycle, port 0 reads 0x05 → rd_success_o[0]=1 with data 0xBEEF.
  - Following cycle, occupancy_o=0 and a re-read fails.
- Multi-consumer: write 0x06 cnt 3, then ports 0 and 1 read 0x06 in the same cycle.
  - Expected: both succeed, and cnt becomes 1.
  - Next cycle, port 1 alone succeeds and the entry frees (occupancy 1→0).
- Over-subscription: with cnt=1 and both ports reading → only port 0 succeeds.
- Tag mismatch and slot busy: entry 0x05 is valid.
  - Reading 0x09 (same index 1, different tag) → success 0.
  - Writing 0x09 → wr_success_o=0, and the entry keeps 0xBEEF.
- Free/rewrite same cycle: a last read of 0x05 together with a write of 0x09 in the same cycle → the write is rejected.
  - A retry of the write 1 cycle later is accepted.
  - Also, a write with cnt=0 is rejected.
- Flush and reset: fill all 4 entries (occupancy_o=4).
  - Assert flush_i together with a write and reads → every success output is 0.
  - Next cycle, occupancy_o=0 and all reads miss.
  - Repeat the sequence using reset instead of flush_i → same response.
